// File: rtl/tx_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_link_arbiter
// Purpose  : Round-robin packetiser sharing one TX link across NSRC FWFT FIFOs.
//            Optional macro TXARB_PRIO0_EN gives source 0 strict priority.
// Revision : 1.0
// ============================================================================
module tx_link_arbiter #(
    parameter int          WIDTH     = 32,
    parameter int          NSRC      = 4,
    parameter int          MAX_BURST = 64,
    parameter logic [7:0]  HDR_TAG   = 8'hA5,
    parameter logic [7:0]  TRL_TAG   = 8'h5A
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    link_active,
    input  logic [NSRC*WIDTH-1:0]   src_data_i,
    input  logic [NSRC-1:0]         src_empty_i,
    output logic [NSRC-1:0]         src_read_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic                    out_empty_o,
    input  logic                    out_read_i,
    output logic                    busy_o,
    output logic [3:0]              cur_src_o
);
    localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_DATA    = 2'd2,
        S_TRAILER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        pkt_seq_q, pkt_seq_d;
    logic [SEL_W-1:0]   grant;
    logic               grant_vld;
    logic [SEL_W-1:0]   next_ptr;
    logic [16:0]        count_inc;
    logic               rd_ok;
    logic [WIDTH-1:0]   src_word [NSRC];

    for (genvar k = 0; k < NSRC; k++) begin : g_unpack
        assign src_word[k] = src_data_i[k*WIDTH +: WIDTH];
    end

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant     = rr_ptr_q;
        for (int i = NSRC - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            if (!src_empty_i[SEL_W'(idx)]) begin
                grant     = SEL_W'(idx);
                grant_vld = 1'b1;
            end
        end
`ifdef TXARB_PRIO0_EN
        if (!src_empty_i[0]) begin
            grant     = '0;
            grant_vld = 1'b1;
        end
`endif
    end

    assign next_ptr  = (sel_q == SEL_W'(NSRC - 1)) ? '0 : sel_q + SEL_W'(1);
    assign count_inc = {1'b0, count_q} + 17'd1;
    assign rd_ok     = out_read_i & link_active;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        count_d     = count_q;
        pkt_seq_d   = pkt_seq_q;
        out_empty_o = 1'b1;
        out_data_o  = '0;
        src_read_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (link_active && grant_vld) begin
                    sel_d   = grant;
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                out_empty_o = 1'b0;
                out_data_o  = WIDTH'({HDR_TAG, 8'(sel_q), pkt_seq_q});
                if (rd_ok) begin
                    count_d = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                out_empty_o = src_empty_i[sel_q];
                out_data_o  = src_word[sel_q];
                if (src_empty_i[sel_q]) begin
                    state_d = S_TRAILER;
                end else if (rd_ok) begin
                    src_read_o[sel_q] = 1'b1;
                    count_d           = count_inc[15:0];
                    if (count_inc == 17'(MAX_BURST)) begin
                        state_d = S_TRAILER;
                    end
                end
            end
            S_TRAILER: begin
                out_empty_o = 1'b0;
                out_data_o  = WIDTH'({TRL_TAG, 8'(sel_q), count_q});
                if (rd_ok) begin
                    state_d   = S_IDLE;
                    pkt_seq_d = pkt_seq_q + 16'd1;
`ifdef TXARB_PRIO0_EN
                    if (sel_q != '0) begin
                        rr_ptr_d = next_ptr;
                    end
`else
                    rr_ptr_d = next_ptr;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Link drop abandons the packet; rr_ptr untouched so the source is re-granted.
        if (!link_active) begin
            out_empty_o = 1'b1;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            count_q   <= '0;
            pkt_seq_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            count_q   <= count_d;
            pkt_seq_q <= pkt_seq_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign cur_src_o = 4'(sel_q);

endmodule
`default_nettype wire

// File: tb/tb_tx_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_link_arbiter
// Purpose  : Randomised, packet-level scoreboard bench for tx_link_arbiter.
// Revision : 1.0
// ============================================================================
module tb_tx_link_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           link_active;
    logic [N*W-1:0] src_data_i;
    logic [N-1:0]   src_empty_i;
    logic [N-1:0]   src_read_o;
    logic [W-1:0]   out_data_o;
    logic           out_empty_o;
    logic           out_read_i;
    logic           busy_o;
    logic [3:0]     cur_src_o;

    tx_link_arbiter #(.WIDTH(W), .NSRC(N), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .link_active (link_active),
        .src_data_i  (src_data_i),
        .src_empty_i (src_empty_i),
        .src_read_o  (src_read_o),
        .out_data_o  (out_data_o),
        .out_empty_o (out_empty_o),
        .out_read_i  (out_read_i),
        .busy_o      (busy_o),
        .cur_src_o   (cur_src_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        pl;
        logic [3:0]  s;
    } exp_t;

    logic [31:0] fq [N][$];
    exp_t        expq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pl_pops = 0;
    int          popcnt [N];
    logic [3:0]  rr_m;
    logic [15:0] seq_m;
    logic [N-1:0] rd_s;
    logic        hold_en;
    logic [31:0] hold_word;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input logic [31:0] d, input logic pl, input int s);
        exp_t e;
        e.d  = d;
        e.pl = pl;
        e.s  = 4'(s);
        expq.push_back(e);
    endfunction

    function automatic void drive_src();
        for (int k = 0; k < N; k++) begin
            src_empty_i[k]       = (fq[k].size() == 0);
            src_data_i[k*W +: W] = (fq[k].size() == 0) ? (32'hDEAD_0000 | 32'(k)) : fq[k][0];
        end
    endfunction

    // Packet-level reference: drain copies of the source queues by the arbitration rules.
    task automatic model_round();
        logic [31:0] mq [N][$];
        logic [31:0] w;
        int s;
        int n;
        for (int k = 0; k < N; k++) mq[k] = fq[k];
        for (int guard = 0; guard < 1000; guard++) begin
            s = -1;
            for (int i = 0; i < N; i++)
                if (s < 0 && mq[(int'(rr_m) + i) % N].size() != 0) s = (int'(rr_m) + i) % N;
`ifdef TXARB_PRIO0_EN
            if (mq[0].size() != 0) s = 0;
`endif
            if (s < 0) break;
            push_exp({8'hA5, 8'(s), seq_m}, 1'b0, s);
            n = 0;
            while (n < MB && mq[s].size() != 0) begin
                w = mq[s].pop_front();
                push_exp(w, 1'b1, s);
                n++;
            end
            push_exp({8'h5A, 8'(s), 16'(n)}, 1'b0, s);
            seq_m++;
`ifdef TXARB_PRIO0_EN
            if (s != 0) rr_m = 4'((s + 1) % N);
`else
            rr_m = 4'((s + 1) % N);
`endif
        end
    endtask

    task automatic monitor();
        exp_t e;
        rd_s = src_read_o;
        if (!link_active) begin
            chk("down_empty", 32'(out_empty_o), 32'd1);
            chk("down_rd", 32'(src_read_o), 32'd0);
        end
        if (hold_en) begin
            chk("hold_data", out_data_o, hold_word);
            chk("hold_empty", 32'(out_empty_o), 32'd0);
            chk("hold_rd", 32'(src_read_o), 32'd0);
        end
        if (out_read_i && !out_empty_o) begin
            chk("exp_avail", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("data", out_data_o, e.d);
                chk("src_rd", 32'(src_read_o), e.pl ? (32'd1 << e.s) : 32'd0);
                chk("cur_src", 32'(cur_src_o), 32'(e.s));
                chk("busy", 32'(busy_o), 32'd1);
                if (e.pl) pl_pops++;
            end
        end else begin
            chk("no_pop_rd", 32'(src_read_o), 32'd0);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic step(input logic la, input logic rd);
        link_active = la;
        out_read_i  = rd;
        drive_src();
        @(negedge clk);
        monitor();
        @(posedge clk);
        for (int k = 0; k < N; k++)
            if (rd_s[k]) begin
                popcnt[k]++;
                if (fq[k].size() != 0) void'(fq[k].pop_front());
            end
        #1;
    endtask

    task automatic run(input bit rnd);
        int cyc;
        cyc = 0;
        while (expq.size() != 0 && cyc < 3000) begin
            step(1'b1, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            cyc++;
        end
        chk("stream_done", 32'(expq.size()), 32'd0);
        expq.delete();
        repeat (3) step(1'b1, 1'b1);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_empty", 32'(out_empty_o), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_empty", 32'(out_empty_o), 32'd1);
        chk("rst_data", out_data_o, 32'd0);
        chk("rst_rd", 32'(src_read_o), 32'd0);
        chk("rst_cur", 32'(cur_src_o), 32'd0);
        for (int k = 0; k < N; k++) begin
            fq[k].delete();
            popcnt[k] = 0;
        end
        link_active = 1'b0;
        out_read_i  = 1'b0;
        drive_src();
        expq.delete();
        rr_m    = '0;
        seq_m   = '0;
        pl_pops = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] first;
        rst_n = 1'b1;
        link_active = 1'b0;
        out_read_i = 1'b0;
        hold_en = 1'b0;
        hold_word = '0;
        for (int k = 0; k < N; k++) popcnt[k] = 0;
        drive_src();
        #2;
        do_reset();

        // Single short packet from source 2
        fq[2].push_back(32'h11); fq[2].push_back(32'h22); fq[2].push_back(32'h33);
        model_round();
        run(1'b0);
        chk("src2_pulses", 32'(popcnt[2]), 32'd3);

        // Long source split into MAX_BURST packets
        do_reset();
        for (int i = 0; i < 10; i++) fq[0].push_back(32'h1000 + 32'(i));
        model_round();
        run(1'b1);

        // All sources, two rounds, then sequence wrap
        do_reset();
        for (int k = 0; k < N; k++) fq[k].push_back(32'h2000 + 32'(k));
        model_round();
        run(1'b1);
        for (int k = 0; k < N; k++) fq[k].push_back(32'h2100 + 32'(k));
        model_round();
        run(1'b1);
        force dut.pkt_seq_q = 16'hFFFF;
        step(1'b1, 1'b0);
        release dut.pkt_seq_q;
        seq_m = 16'hFFFF;
        fq[0].push_back(32'h2200); fq[1].push_back(32'h2201);
        model_round();
        run(1'b1);

        // Link drop mid-DATA after two payload pops of source 1
        do_reset();
        for (int i = 0; i < 5; i++) fq[1].push_back(32'h200 + 32'(i));
        push_exp(32'hA501_0000, 1'b0, 1);
        push_exp(32'h200, 1'b1, 1);
        push_exp(32'h201, 1'b1, 1);
        push_exp(32'hA501_0000, 1'b0, 1);
        push_exp(32'h202, 1'b1, 1);
        push_exp(32'h203, 1'b1, 1);
        push_exp(32'h204, 1'b1, 1);
        push_exp(32'h5A01_0003, 1'b0, 1);
        for (int c = 0; c < 50 && pl_pops < 2; c++) step(1'b1, 1'b1);
        chk("abort_reached", 32'(pl_pops), 32'd2);
        step(1'b0, 1'b1);
        chk("abort_idle", 32'(busy_o), 32'd0);
        run(1'b0);

        // Header held while the controller stalls
        do_reset();
        fq[3].push_back(32'h300); fq[3].push_back(32'h301);
        model_round();
        step(1'b1, 1'b0);
        hold_word = 32'hA503_0000;
        hold_en = 1'b1;
        repeat (5) step(1'b1, 1'b0);
        hold_en = 1'b0;
        chk("hold_no_pops", 32'(popcnt[3]), 32'd0);
        run(1'b1);

        // Sources 0 and 1 pending with rr_ptr at 1
        do_reset();
        fq[0].push_back(32'h400);
        model_round();
        run(1'b1);
        fq[0].push_back(32'h401); fq[1].push_back(32'h411);
        model_round();
`ifdef TXARB_PRIO0_EN
        first = 4'd0;
`else
        first = 4'd1;
`endif
        step(1'b1, 1'b0);
        chk("prio_grant", 32'(cur_src_o), 32'(first));
        run(1'b1);

        // Asynchronous reset in the middle of a packet
        do_reset();
        for (int i = 0; i < 3; i++) fq[3].push_back(32'h500 + 32'(i));
        model_round();
        repeat (3) step(1'b1, 1'b1);
        chk("busy_mid", 32'(busy_o), 32'd1);
        do_reset();

        // Random rounds with state carried across rounds
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < N; k++) begin
                int nw;
                nw = $urandom_range(0, 9);
                for (int i = 0; i < nw; i++) fq[k].push_back($urandom);
            end
            model_round();
            run(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
